snake_line_renderer: RTL and testbench

- Read-side counterpart of the snake state writer: consumes `snake`, `food` and `has_food` and turns them into per-pixel object codes for the VGA pixel path.
- Works one scanline ahead into a ping-pong line buffer: while row y is displayed from one bank, row y+1 is rasterised into the other.
- Avoids evaluating `max_length` circle tests in parallel on every pixel.

---
 rtl/snake_line_renderer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_snake_line_renderer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_line_renderer.sv
// snake_line_renderer
//
// Turns the live snake and the food position into per-pixel object codes,
// one scanline ahead of the display. Two line banks ping-pong: the display
// bank feeds pixel_kind while the other bank is rasterised for the next row.
// Each object is drawn as horizontal runs of a circle, one pixel per cycle.
//
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   snake       packed snake: {length[LEN_W-1:0], pt[MAX_LENGTH-1], ..., pt[0]},
//               each pt = {x[X_W-1:0], y[Y_W-1:0]}; pt[0] is the head
//   food        food centre {x, y}
//   has_food    food present
//   line_start  one-cycle pulse: swap banks and start building build_row
//   build_row   row to rasterise, sampled on line_start
//   pixel_x     current display column
//   pixel_kind  0 none, 1 food, 2 body, 3 head; one cycle after pixel_x
//   busy        a build is in progress
//   overrun     sticky: line_start arrived while busy (cleared only by reset)
module snake_line_renderer #(
    parameter  int H_ACTIVE   = 640,
    parameter  int V_ACTIVE   = 480,
    parameter  int MAX_LENGTH = 8,
    parameter  int RADIUS     = 8,
    localparam int X_W        = $clog2(H_ACTIVE),
    localparam int Y_W        = $clog2(V_ACTIVE),
    localparam int LEN_W      = $clog2(MAX_LENGTH + 1),
    localparam int PT_W       = X_W + Y_W,
    localparam int SNAKE_W    = LEN_W + MAX_LENGTH * PT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [SNAKE_W-1:0] snake,
    input  logic [PT_W-1:0]    food,
    input  logic               has_food,
    input  logic               line_start,
    input  logic [Y_W-1:0]     build_row,
    input  logic [X_W-1:0]     pixel_x,
    output logic [1:0]         pixel_kind,
    output logic               busy,
    output logic               overrun
);

    localparam int SEG_W = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam int CW    = X_W + 2;               // signed column arithmetic
    localparam int DW    = Y_W + 1;               // signed row difference
    localparam int RI_W  = $clog2(RADIUS + 1);    // half-width table index

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FOOD_SETUP, S_FOOD_FILL, S_SEG_SETUP, S_SEG_FILL
    } state_t;

    // Largest w with w*w + d*d <= RADIUS*RADIUS, evaluated at elaboration.
    function automatic int half_width(input int d);
        int w;
        w = 0;
        for (int i = 0; i <= RADIUS; i++)
            if (i * i + d * d <= RADIUS * RADIUS) w = i;
        return w;
    endfunction

    logic [CW-1:0] hw_tab [RADIUS+1];
    for (genvar d = 0; d <= RADIUS; d++) begin : g_hw
        assign hw_tab[d] = CW'(half_width(d));
    end

    logic [X_W-1:0] seg_x [MAX_LENGTH];
    logic [Y_W-1:0] seg_y [MAX_LENGTH];
    for (genvar i = 0; i < MAX_LENGTH; i++) begin : g_seg
        assign seg_x[i] = snake[i*PT_W+Y_W +: X_W];
        assign seg_y[i] = snake[i*PT_W +: Y_W];
    end

    logic [LEN_W-1:0] snake_len;
    assign snake_len = snake[SNAKE_W-1 -: LEN_W];

    state_t           state_q, state_d;
    logic             disp_q, disp_d;
    logic [Y_W-1:0]   row_q, row_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [X_W-1:0]   fx_q, fx_d;
    logic [Y_W-1:0]   fy_q, fy_d;
    logic             has_food_q, has_food_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [X_W-1:0]   xe_q, xe_d;
    logic [1:0]       valid_q, valid_d;      // bank has completed a build
    logic             overrun_q, overrun_d;
    logic [1:0]       pixel_kind_q, pixel_kind_d;

    logic [1:0]       line_mem [2][H_ACTIVE];
    logic             build_bank;
    logic             wr_en;
    logic [1:0]       wr_data;

    assign build_bank = ~disp_q;

    // Circle-run setup for the current object.
    logic                 in_food;
    logic [X_W-1:0]       cx;
    logic [Y_W-1:0]       cy;
    logic signed [DW-1:0] dy_diff;
    logic [DW-1:0]        dy_abs;
    logic                 in_rows;
    logic [RI_W-1:0]      dy_idx;
    logic signed [CW-1:0] cx_s, w_s, xs_s, xe_s;
    logic [X_W-1:0]       xs_c, xe_c;
    logic                 obj_hit;

    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block; a path that leaves it unassigned would infer a latch.
    always_comb begin
        in_food = (state_q == S_FOOD_SETUP) || (state_q == S_FOOD_FILL);
        cx      = in_food ? fx_q : seg_x[seg_q];
        cy      = in_food ? fy_q : seg_y[seg_q];
        dy_diff = $signed({1'b0, row_q}) - $signed({1'b0, cy});
        dy_abs  = dy_diff[DW-1] ? DW'(-dy_diff) : DW'(dy_diff);
        in_rows = (dy_abs <= DW'(RADIUS));
        dy_idx  = in_rows ? dy_abs[RI_W-1:0] : '0;
        cx_s    = $signed({2'b00, cx});
        w_s     = $signed(hw_tab[dy_idx]);
        xs_s    = cx_s - w_s;
        xe_s    = cx_s + w_s;
        xs_c    = xs_s[CW-1] ? '0 : xs_s[X_W-1:0];
        xe_c    = (xe_s > $signed(CW'(H_ACTIVE - 1))) ? X_W'(H_ACTIVE - 1)
                                                      : xe_s[X_W-1:0];
        // An off-screen centre can leave an empty run; skip it.
        obj_hit = in_rows && (xs_c <= xe_c);
    end

    logic advance;
    logic pix_in_range;

    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        row_d        = row_q;
        len_d        = len_q;
        fx_d         = fx_q;
        fy_d         = fy_q;
        has_food_d   = has_food_q;
        seg_d        = seg_q;
        x_d          = x_q;
        xe_d         = xe_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        wr_en        = 1'b0;
        wr_data      = 2'd0;
        advance      = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
                wr_en = 1'b1;
                if (x_q == X_W'(H_ACTIVE - 1)) begin
                    if (has_food_q) begin
                        state_d = S_FOOD_SETUP;
                    end else begin
                        state_d = S_SEG_SETUP;
                        seg_d   = SEG_W'(len_q - LEN_W'(1));
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            S_FOOD_SETUP, S_SEG_SETUP: begin
                if (obj_hit) begin
                    x_d     = xs_c;
                    xe_d    = xe_c;
                    state_d = in_food ? S_FOOD_FILL : S_SEG_FILL;
                end else begin
                    advance = 1'b1;
                end
            end
            S_FOOD_FILL, S_SEG_FILL: begin
                wr_en   = 1'b1;
                wr_data = in_food ? 2'd1 : ((seg_q == '0) ? 2'd3 : 2'd2);
                if (x_q == xe_q) advance = 1'b1;
                else             x_d     = x_q + X_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Objects are drawn food, tail..segment 1, head: later writes win.
        if (advance) begin
            if (in_food) begin
                state_d = S_SEG_SETUP;
                seg_d   = SEG_W'(len_q - LEN_W'(1));
            end else if (seg_q == '0) begin
                state_d             = S_IDLE;
                valid_d[build_bank] = 1'b1;
            end else begin
                state_d = S_SEG_SETUP;
                seg_d   = seg_q - SEG_W'(1);
            end
        end

        // A new line always wins; an unfinished build is abandoned as-is.
        if (line_start) begin
            if (state_q != S_IDLE) overrun_d = 1'b1;
            valid_d    = valid_q;
            wr_en      = 1'b0;
            disp_d     = ~disp_q;
            row_d      = build_row;
            fx_d       = food[PT_W-1 -: X_W];
            fy_d       = food[Y_W-1:0];
            has_food_d = has_food;
            if (snake_len == '0)                       len_d = LEN_W'(1);
            else if (snake_len > LEN_W'(MAX_LENGTH))   len_d = LEN_W'(MAX_LENGTH);
            else                                       len_d = snake_len;
            x_d        = '0;
            state_d    = S_CLEAR;
        end
    end

    always_comb begin
        pix_in_range = ({1'b0, pixel_x} < (X_W + 1)'(H_ACTIVE));
        pixel_kind_d = 2'd0;
        if (pix_in_range && valid_q[disp_q])
            pixel_kind_d = line_mem[disp_q][pixel_x];
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            disp_q       <= 1'b0;
            row_q        <= '0;
            len_q        <= LEN_W'(1);
            fx_q         <= '0;
            fy_q         <= '0;
            has_food_q   <= 1'b0;
            seg_q        <= '0;
            x_q          <= '0;
            xe_q         <= '0;
            valid_q      <= 2'b00;
            overrun_q    <= 1'b0;
            pixel_kind_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            row_q        <= row_d;
            len_q        <= len_d;
            fx_q         <= fx_d;
            fy_q         <= fy_d;
            has_food_q   <= has_food_d;
            seg_q        <= seg_d;
            x_q          <= x_d;
            xe_q         <= xe_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            pixel_kind_q <= pixel_kind_d;
        end
    end

    // NOTE: the line banks have no reset; each is cleared by its own build
    // and gated by valid_q until then, so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_en) line_mem[build_bank][x_q] <= wr_data;
    end

    assign pixel_kind = pixel_kind_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_snake_line_renderer.sv
// Self-checking bench for snake_line_renderer. A circle-membership model
// produces the expected row for every line_start; a compare process checks
// pixel_kind on every clock, and directed probes pin hand-computed columns.
module tb_snake_line_renderer;

    localparam int H       = 640;
    localparam int V       = 480;
    localparam int ML      = 8;
    localparam int R       = 8;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int LEN_W   = 4;
    localparam int PT_W    = X_W + Y_W;
    localparam int SNAKE_W = LEN_W + ML * PT_W;
    localparam int WORST   = H + (ML + 1) * (2 * R + 2);

    logic               clock = 1'b0;
    logic               reset_n;
    logic [SNAKE_W-1:0] snake;
    logic [PT_W-1:0]    food;
    logic               has_food;
    logic               line_start;
    logic [Y_W-1:0]     build_row;
    logic [X_W-1:0]     pixel_x;
    logic [1:0]         pixel_kind;
    logic               busy;
    logic               overrun;

    always #5 clock = ~clock;

    snake_line_renderer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .MAX_LENGTH(ML), .RADIUS(R)
    ) dut (
        .clock(clock), .reset_n(reset_n), .snake(snake), .food(food),
        .has_food(has_food), .line_start(line_start), .build_row(build_row),
        .pixel_x(pixel_x), .pixel_kind(pixel_kind), .busy(busy),
        .overrun(overrun)
    );

    // Scene description, packed onto the DUT ports.
    int snk_len;
    int snk_x [ML];
    int snk_y [ML];
    int food_x, food_y;

    always_comb begin
        snake = '0;
        snake[SNAKE_W-1 -: LEN_W] = LEN_W'(snk_len);
        for (int i = 0; i < ML; i++)
            snake[i*PT_W +: PT_W] = {X_W'(snk_x[i]), Y_W'(snk_y[i])};
        food = {X_W'(food_x), Y_W'(food_y)};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: a pixel belongs to an object when it lies inside its circle;
    // head beats body beats food.
    function automatic bit in_circle(input int x, input int y,
                                     input int cx, input int cy);
        return (x - cx) * (x - cx) + (y - cy) * (y - cy) <= R * R;
    endfunction

    function automatic int model_kind(input int row, input int x);
        int len;
        int k;
        len = (snk_len < 1) ? 1 : ((snk_len > ML) ? ML : snk_len);
        k   = 0;
        if (has_food && in_circle(x, row, food_x, food_y)) k = 1;
        for (int i = 1; i < len; i++)
            if (in_circle(x, row, snk_x[i], snk_y[i])) k = 2;
        if (in_circle(x, row, snk_x[0], snk_y[0])) k = 3;
        return k;
    endfunction

    int disp_line [H];
    int pend_line [H];
    bit disp_ok   = 1'b0;   // displayed row is a fully built model row
    bit built_ok  = 1'b0;   // the pending row finished building
    bit ever_done = 1'b0;   // some build has completed since reset

    // Compare process: every cycle, then follow bank swaps.
    always @(posedge clock) begin
        #1;
        if (!ever_done)
            check("pix_blank", 32'(pixel_kind), 0);
        else if (disp_ok)
            check($sformatf("pix_model x=%0d", pixel_x), 32'(pixel_kind),
                  (int'(pixel_x) < H) ? disp_line[pixel_x] : 0);
        if (!reset_n) begin
            disp_ok = 1'b0;
        end else if (line_start) begin
            for (int x = 0; x < H; x++) disp_line[x] = pend_line[x];
            disp_ok  = built_ok;
            built_ok = 1'b0;
            for (int x = 0; x < H; x++) pend_line[x] = model_kind(int'(build_row), x);
        end
    end

    task automatic clear_scene();
        snk_len  = 1;
        for (int i = 0; i < ML; i++) begin
            snk_x[i] = 0;
            snk_y[i] = 470;
        end
        has_food = 1'b0;
        food_x   = 0;
        food_y   = 470;
    endtask

    task automatic pulse_ls(input int row);
        @(negedge clock);
        build_row  = Y_W'(row);
        line_start = 1'b1;
        @(negedge clock);
        line_start = 1'b0;
    endtask

    task automatic wait_build(output int cycles);
        cycles = 0;
        forever begin
            @(posedge clock);
            #1;
            cycles++;
            if (!busy) begin
                built_ok  = 1'b1;
                ever_done = 1'b1;
                break;
            end
            if (cycles >= 2000) begin
                check("build_timeout busy", 32'(busy), 0);
                break;
            end
        end
    endtask

    task automatic sweep();
        for (int x = 0; x < H + 40; x++) begin
            @(negedge clock);
            pixel_x = X_W'(x);
        end
    endtask

    task automatic line(input int row);
        int c;
        pulse_ls(row);
        sweep();
        wait_build(c);
    endtask

    task automatic probe(input int x, input int exp);
        @(negedge clock);
        pixel_x = X_W'(x);
        @(posedge clock);
        #1;
        check($sformatf("probe x=%0d", x), 32'(pixel_kind), exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        reset_n    = 1'b0;
        line_start = 1'b0;
        build_row  = '0;
        pixel_x    = '0;
        clear_scene();
        repeat (3) @(negedge clock);
        check("reset busy", 32'(busy), 0);
        check("reset overrun", 32'(overrun), 0);
        check("reset pixel_kind", 32'(pixel_kind), 0);
        reset_n = 1'b1;

        // 1: single head at (320,240)
        snk_x[0] = 320; snk_y[0] = 240;
        pulse_ls(240);
        @(posedge clock);
        #1;
        check("busy after line_start", 32'(busy), 1);
        sweep();
        wait_build(c);

        // 2: food at (100,50); head stays far away
        has_food = 1'b1; food_x = 100; food_y = 50;
        line(58);
        probe(312, 3); probe(328, 3); probe(320, 3);
        probe(311, 0); probe(329, 0); probe(0, 0);
        line(59);
        probe(100, 1); probe(99, 0); probe(101, 0); probe(320, 0);

        // 3: head, one body segment and food overlapping on row 240
        snk_len  = 2;
        snk_x[1] = 324; snk_y[1] = 240;
        food_x   = 316; food_y   = 240;
        line(240);
        probe(100, 0);

        // 4a: head near the left edge
        clear_scene();
        snk_x[0] = 3; snk_y[0] = 100;
        line(100);
        probe(312, 3); probe(328, 3); probe(329, 2); probe(332, 2);
        probe(308, 1); probe(311, 1); probe(333, 0); probe(307, 0);

        // 4b: head near the right edge
        snk_x[0] = 636;
        line(100);
        probe(0, 3); probe(11, 3); probe(12, 0); probe(639, 0); probe(635, 0);

        // 6: worst case, every object fully on row 200
        snk_len = ML;
        for (int i = 0; i < ML; i++) begin
            snk_x[i] = 40 + 70 * i;
            snk_y[i] = 200;
        end
        has_food = 1'b1; food_x = 600; food_y = 200;
        pulse_ls(200);
        wait_build(c);
        check("worst-case build within bound", 32'(c <= WORST + 1), 1);
        probe(628, 3); probe(639, 3); probe(627, 0); probe(700, 0);
        line(0);
        probe(40, 3); probe(48, 3); probe(49, 0); probe(102, 2);
        probe(118, 2); probe(600, 1); probe(608, 1); probe(609, 0);

        // 5: line_start reissued mid-build
        clear_scene();
        snk_x[0] = 320; snk_y[0] = 240;
        check("overrun before", 32'(overrun), 0);
        pulse_ls(240);
        repeat (8) @(negedge clock);
        pulse_ls(240);
        @(posedge clock);
        #1;
        check("overrun set", 32'(overrun), 1);
        wait_build(c);
        check("overrun held", 32'(overrun), 1);
        line(240);
        line(0);
        probe(320, 3); probe(311, 0);
        check("overrun still held", 32'(overrun), 1);

        // Reset in the middle of a build
        pulse_ls(240);
        repeat (50) @(negedge clock);
        #2;
        reset_n   = 1'b0;
        ever_done = 1'b0;
        built_ok  = 1'b0;
        #1;
        check("async reset busy", 32'(busy), 0);
        check("async reset overrun", 32'(overrun), 0);
        check("async reset pixel_kind", 32'(pixel_kind), 0);
        @(negedge clock);
        reset_n = 1'b1;
        line(240);
        line(0);
        probe(312, 3); probe(311, 0);
        check("overrun after reset", 32'(overrun), 0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
